audsample2fifo: RTL and testbench
=================================

// Module: audsample2fifo
// PURPOSE
//  Producer side of the audio PWM sample FIFO: accepts a stream of unsigned DATA_WIDTH-bit
//  samples over a valid/ready handshake and packs LANES = FIFO_DATA_WIDTH/DATA_WIDTH samples
//  per FIFO word. Sample k of a word goes to bits [k*DATA_WIDTH +: DATA_WIDTH], so lane 0
//  (bits [7:0]) is played first by the PWM reader. Sits between the sample source and the FIFO write port.
// PARAMETERS
//  DATA_WIDTH       8      bits per sample
//  FIFO_DATA_WIDTH  32     FIFO word width; must be an integer multiple of DATA_WIDTH (4 lanes at defaults)
//  PAD_VALUE        8'h80  fill value for unused lanes on flush (PWM mid-scale = silence)
//  CNT_WIDTH        16     width of the written-word counter
// PORTS
//  clk           in   1                clock
//  rst           in   1                synchronous reset, active-high
//  s_data        in   DATA_WIDTH       sample in
//  s_valid       in   1                sample valid
//  s_ready       out  1                sample accepted when s_valid & s_ready
//  flush         in   1                single-cycle pulse: pad and emit the partial word
//  fifo_full     in   1                FIFO full
//  fifo_wr_en    out  1                FIFO write strobe
//  fifo_wr_data  out  FIFO_DATA_WIDTH  FIFO write data
//  word_cnt      out  CNT_WIDTH        words written since reset (wraps)
//  busy          out  1                partial word, pending word or pending flush exists
// BEHAVIOUR
//  - Reset: lane=0, asm reg=0, pend=0, flush_pend=0, fifo_wr_en=0, fifo_wr_data=0, word_cnt=0, busy=0.
//  - Two storage stages:
//    - Assembly register asm with lane index lane, range 0..LANES-1.
//    - Output word register out with flag pend. fifo_wr_data = out.
//  - fifo_wr_en = pend & ~fifo_full (combinational). On each write: pend clears and word_cnt increments.
//    word_cnt wraps from all-ones to 0.
//  - s_ready = (lane != LANES-1) | ~pend | ~fifo_full.
//    Input stalls only when completing a word would overwrite an unwritten out.
//  - Accept: asm[lane] <= s_data.
//    - If lane < LANES-1: lane increments.
//    - Else: out <= the completed word, pend=1, lane=0.
//      The full word is built from asm plus the current s_data.
//  - Latency: the last sample is accepted in cycle N; fifo_wr_en is high in cycle N+1 if fifo_full=0.
//    Sustained throughput is 1 sample/clk.
//  - Simultaneous events in one cycle: writing the old out and loading a new out are both legal.
//    The write uses the old value; pend stays 1.
//  - flush:
//    - Sets flush_pend if lane != 0; no effect if lane == 0.
//    - If a sample is accepted in the same cycle, that sample is placed first.
//      The flush then covers the remaining lanes (lane is evaluated after the accept).
//    - While flush_pend=1 and the out stage is free (~pend, or being written this cycle):
//      - out <= asm with lanes >= lane set to PAD_VALUE.
//      - pend=1, lane=0, flush_pend=0.
//    - s_ready=0 while flush_pend=1.
//    - If lane wraps to 0 exactly on the flush cycle, flush_pend is not set and nothing is padded.
//  - fifo_full held high:
//    - out holds.
//    - Input continues until asm holds LANES-1 samples, then s_ready=0.
//    - Nothing is lost or duplicated.
//  - busy = (lane != 0) | pend | flush_pend.
//  - rst mid-word or mid-flush: the partial word and pending word are discarded.
//    No write is issued in the reset cycle.
// CONFIGURATION
//  AUDSAMPLE_SIGNED_IN_EN
//  - Defined: s_data is two's complement. The MSB is inverted on accept, converting to offset binary
//    (8'h80 -> 8'h00, 8'h7F -> 8'hFF, 8'h00 -> 8'h80). PAD_VALUE is inserted unconverted.
//  - Undefined: s_data is stored unmodified.
// TESTING
//  1. Stream 01,02,03,04,05,06,07,08 with s_valid=1 and fifo_full=0.
//     -> Writes 32'h04030201, then 32'h08070605, each 1 clk after its 4th accept; word_cnt=2.
//  2. Send AA,BB, then a flush pulse. -> One write of 32'h8080BBAA; busy=0 afterwards.
//  3. Send 11 and flush in the same cycle. -> Write 32'h80808011.
//     Flush with lane=0 and pend=0. -> No write.
//  4. Hold fifo_full=1 and stream 12 samples.
//     -> s_ready drops after 7 accepts; release full -> words 1 and 2 are written in order,
//        every sample exactly once.
//  5. Send 3 samples, assert rst for 1 clk, then send 21,22,23,24.
//     -> Only 32'h24232221 is written; word_cnt=1.
//  6. With AUDSAMPLE_SIGNED_IN_EN defined, send 80,7F,00,FF. -> Write 32'h7F80FF00.

Source files
------------

// File: rtl/audsample2fifo.sv
// audsample2fifo: packs DATA_WIDTH samples into FIFO words, lane 0 in the LSBs, with pad-on-flush
// Define AUDSAMPLE_SIGNED_IN_EN to accept two's-complement samples (MSB inverted to offset binary)
module audsample2fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE = 8'h80,
    parameter int CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic                       flush,
    input  logic                       fifo_full,
    output logic                       fifo_wr_en,
    output logic [FIFO_DATA_WIDTH-1:0] fifo_wr_data,
    output logic [CNT_WIDTH-1:0]       word_cnt,
    output logic                       busy
);
    localparam int LANES = FIFO_DATA_WIDTH / DATA_WIDTH;
    localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
    localparam logic [LW-1:0] LAST = LW'(LANES - 1);

    logic [LW-1:0] lane, lane_acc;
    logic [FIFO_DATA_WIDTH-1:0] asm_q, asm_d, pad_word;
    logic [DATA_WIDTH-1:0] din;
    logic pend, flush_pend, acc, last, complete, do_flush;

`ifdef AUDSAMPLE_SIGNED_IN_EN
    assign din = {~s_data[DATA_WIDTH-1], s_data[DATA_WIDTH-2:0]};
`else
    assign din = s_data;
`endif

    assign last = lane == LAST;
    assign fifo_wr_en = pend & ~fifo_full & ~rst;
    // only the word-completing sample needs the out stage free
    assign s_ready = ~flush_pend & (~last | ~pend | ~fifo_full);
    assign acc = s_valid & s_ready;
    assign complete = acc & last;
    assign lane_acc = acc ? (last ? '0 : lane + LW'(1)) : lane;
    assign do_flush = flush_pend & (~pend | fifo_wr_en);
    assign busy = (lane != '0) | pend | flush_pend;

    always_comb begin
        asm_d = asm_q;
        if (acc) asm_d[int'(lane)*DATA_WIDTH +: DATA_WIDTH] = din;
        pad_word = asm_q;
        for (int k = 0; k < LANES; k++)
            if (k >= int'(lane)) pad_word[k*DATA_WIDTH +: DATA_WIDTH] = PAD_VALUE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane <= '0;
            asm_q <= '0;
            pend <= 1'b0;
            flush_pend <= 1'b0;
            fifo_wr_data <= '0;
            word_cnt <= '0;
        end else begin
            asm_q <= asm_d;
            lane <= do_flush ? '0 : lane_acc;
            if (complete | do_flush) begin
                fifo_wr_data <= complete ? asm_d : pad_word;
                pend <= 1'b1;
            end else if (fifo_wr_en) begin
                pend <= 1'b0;
            end
            // lane_acc reflects a same-cycle accept, so a wrap to 0 leaves nothing to pad
            flush_pend <= ~do_flush & (flush_pend | (flush & (lane_acc != '0)));
            if (fifo_wr_en) word_cnt <= word_cnt + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_audsample2fifo.sv
// tb_audsample2fifo: directed checks of sample packing, flush padding, back-pressure and reset
module tb_audsample2fifo;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        flush = 1'b0;
    logic        fifo_full = 1'b0;
    logic        fifo_wr_en;
    logic [31:0] fifo_wr_data;
    logic [15:0] word_cnt;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] wr_q[$];
    int wr_cyc[$];
    int acc_cyc[$];

    audsample2fifo dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .flush(flush), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
        .fifo_wr_data(fifo_wr_data), .word_cnt(word_cnt), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fifo_wr_en) begin
            wr_q.push_back(fifo_wr_data);
            wr_cyc.push_back(cyc);
        end
        if (s_valid && s_ready) acc_cyc.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic clear_log();
        wr_q.delete();
        wr_cyc.delete();
        acc_cyc.delete();
    endtask

    task automatic send(input logic [7:0] d);
        int n = 0;
        s_valid = 1'b1;
        s_data = d;
        @(negedge clk);
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) check("send_timeout", 32'd0, 32'd1);
        step();
        s_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    initial begin
        int idx;
        logic a;
        idle(2);
        rst = 1'b0;
        check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        check("rst_wr_data", fifo_wr_data, 32'd0);
        check("rst_word_cnt", 32'(word_cnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd1);

        clear_log();
        for (int i = 1; i <= 8; i++) send(8'(i));
        idle(3);
        check("t1_count", 32'(wr_q.size()), 32'd2);
        check("t1_word0", wr_q[0], 32'h04030201);
        check("t1_word1", wr_q[1], 32'h08070605);
        check("t1_lat0", 32'(wr_cyc[0] - acc_cyc[3]), 32'd1);
        check("t1_lat1", 32'(wr_cyc[1] - acc_cyc[7]), 32'd1);
        check("t1_word_cnt", 32'(word_cnt), 32'd2);

        clear_log();
        send(8'hAA);
        send(8'hBB);
        pulse_flush();
        idle(4);
        check("t2_count", 32'(wr_q.size()), 32'd1);
        check("t2_word", wr_q[0], 32'h8080BBAA);
        check("t2_busy", 32'(busy), 32'd0);
        check("t2_word_cnt", 32'(word_cnt), 32'd3);

        clear_log();
        s_valid = 1'b1;
        s_data = 8'h11;
        flush = 1'b1;
        step();
        s_valid = 1'b0;
        flush = 1'b0;
        idle(4);
        check("t3_count", 32'(wr_q.size()), 32'd1);
        check("t3_word", wr_q[0], 32'h80808011);
        clear_log();
        pulse_flush();
        idle(3);
        check("t3_idle_flush", 32'(wr_q.size()), 32'd0);
        check("t3_busy", 32'(busy), 32'd0);
        check("t3_word_cnt", 32'(word_cnt), 32'd4);

        clear_log();
        fifo_full = 1'b1;
        idx = 0;
        repeat (20) begin
            s_valid = idx < 12;
            s_data = 8'(8'h31 + idx);
            @(negedge clk);
            a = s_valid && s_ready;
            step();
            if (a) idx++;
        end
        check("t4_accepts_full", 32'(idx), 32'd7);
        check("t4_stalled", 32'(s_ready), 32'd0);
        check("t4_no_write", 32'(wr_q.size()), 32'd0);
        fifo_full = 1'b0;
        for (int n = 0; n < 40 && idx < 12; n++) begin
            s_valid = 1'b1;
            s_data = 8'(8'h31 + idx);
            @(negedge clk);
            a = s_ready;
            step();
            if (a) idx++;
        end
        s_valid = 1'b0;
        idle(4);
        check("t4_accepts", 32'(idx), 32'd12);
        check("t4_count", 32'(wr_q.size()), 32'd3);
        check("t4_word0", wr_q[0], 32'h34333231);
        check("t4_word1", wr_q[1], 32'h38373635);
        check("t4_word2", wr_q[2], 32'h3C3B3A39);
        check("t4_word_cnt", 32'(word_cnt), 32'd7);

        send(8'h41);
        send(8'h42);
        send(8'h43);
        clear_log();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_cnt", 32'(word_cnt), 32'd0);
        for (int i = 0; i < 4; i++) send(8'(8'h21 + i));
        idle(3);
        check("t5_count", 32'(wr_q.size()), 32'd1);
        check("t5_word", wr_q[0], 32'h24232221);
        check("t5_word_cnt", 32'(word_cnt), 32'd1);

        clear_log();
        send(8'h80);
        send(8'h7F);
        send(8'h00);
        send(8'hFF);
        idle(3);
        check("t6_count", 32'(wr_q.size()), 32'd1);
`ifdef AUDSAMPLE_SIGNED_IN_EN
        check("t6_word", wr_q[0], 32'h7F80FF00);
`else
        check("t6_word", wr_q[0], 32'hFF007F80);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end
endmodule
